pipe_reg_elastic: RTL and testbench

//  Generic elastic pipeline register for the MINA CPU (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_reg_elastic_pkg.sv | 34 +++
 rtl/pipe_reg_elastic.sv | 103 ++++++++++
 tb/tb_pipe_reg_elastic.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_reg_elastic_pkg.sv
// Shared types for the elastic pipeline register and the MINA stage payloads.
// The state encoding and the no-op bubble constants live here so all stages agree on them.
package pipe_reg_elastic_pkg;

   typedef enum logic [1:0] {
      PIPE_EMPTY = 2'd0,
      PIPE_ONE   = 2'd1,
      PIPE_TWO   = 2'd2
   } pipe_state_t;

   typedef enum logic [1:0] {
      MEM_OP_NONE  = 2'd0,
      MEM_OP_LOAD  = 2'd1,
      MEM_OP_STORE = 2'd2
   } mem_op_t;

   typedef struct packed {
      logic [31:0] result;
      logic [4:0]  rd;
      logic        rd_we;
   } wb_params_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      mem_op_t     mem_op;
      logic [4:0]  rd;
   } mem_params_t;

   localparam wb_params_t  WB_PARAMS_BUBBLE  = '{result: 32'h0, rd: 5'd0, rd_we: 1'b0};
   localparam mem_params_t MEM_PARAMS_BUBBLE = '{addr: 32'h0, wdata: 32'h0,
                                                 mem_op: MEM_OP_NONE, rd: 5'd0};

endpackage

// File: rtl/pipe_reg_elastic.sv
// Elastic pipeline register with one-entry skid buffer, registered in_ready and sync flush.
// Define PIPE_STATS_EN to add the saturating stall_cycles counter and its port.
module pipe_reg_elastic
   import pipe_reg_elastic_pkg::*;
#(
   parameter int               WIDTH  = 32,
   parameter logic [WIDTH-1:0] BUBBLE = '0
`ifdef PIPE_STATS_EN
   ,
   parameter int               STALL_CNT_W = 16
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
`ifdef PIPE_STATS_EN
   ,
   output logic [STALL_CNT_W-1:0] stall_cycles
`endif
);

   pipe_state_t      state_q;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] skid_q;
   logic             in_ready_q;
   logic             in_xfer;
   logic             out_xfer;

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != PIPE_EMPTY);
   assign out_data  = main_q;
   assign in_xfer   = in_valid && in_ready_q;
   assign out_xfer  = out_valid && out_ready;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   // NOTE: the data registers are reset too, because downstream decodes out_data as a no-op when idle.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         state_q    <= PIPE_EMPTY;
         main_q     <= BUBBLE;
         skid_q     <= BUBBLE;
         in_ready_q <= 1'b1;
      end else begin
         unique case (state_q)
            PIPE_EMPTY: begin
               if (in_xfer) begin
                  state_q <= PIPE_ONE;
                  main_q  <= in_data;
               end
            end
            PIPE_ONE: begin
               if (in_xfer && out_xfer) begin
                  main_q <= in_data;
               end else if (out_xfer) begin
                  state_q <= PIPE_EMPTY;
                  main_q  <= BUBBLE;
               end else if (in_xfer) begin
                  // Downstream stalled: park the newer payload; main keeps the older one.
                  state_q    <= PIPE_TWO;
                  skid_q     <= in_data;
                  in_ready_q <= 1'b0;
               end
            end
            PIPE_TWO: begin
               if (out_xfer) begin
                  state_q    <= PIPE_ONE;
                  main_q     <= skid_q;
                  skid_q     <= BUBBLE;
                  in_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q    <= PIPE_EMPTY;
               main_q     <= BUBBLE;
               skid_q     <= BUBBLE;
               in_ready_q <= 1'b1;
            end
         endcase
      end
   end

`ifdef PIPE_STATS_EN
   logic [STALL_CNT_W-1:0] stall_q;

   // Only rst_n clears the counter; flush is a pipeline event, not a statistics reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else if (out_valid && !out_ready && (stall_q != '1)) begin
         stall_q <= stall_q + 1'b1;
      end
   end

   assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Self-checking bench for pipe_reg_elastic: directed flow-control cases plus a random
// valid/ready/flush run against a scoreboard queue. Define PIPE_STATS_EN to cover the counter.
module tb_pipe_reg_elastic;

   localparam int         W      = 8;
   localparam logic [7:0] BUB    = 8'hEE;
   localparam int         CNT_W  = 4;

   logic         clk;
   logic         rst_n;
   logic         flush;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
`ifdef PIPE_STATS_EN
   logic [CNT_W-1:0] stall_cycles;
`endif

   int n_checks = 0;
   int n_errors = 0;
   bit mon_en   = 1'b0;

   logic [W-1:0] sb_q[$];
   bit           hold_pend = 1'b0;
   logic [W-1:0] hold_data;

   pipe_reg_elastic #(
      .WIDTH (W),
      .BUBBLE(BUB)
`ifdef PIPE_STATS_EN
      ,
      .STALL_CNT_W(CNT_W)
`endif
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data)
`ifdef PIPE_STATS_EN
      ,
      .stall_cycles(stall_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: outputs are compared at the falling edge, then the model advances for the next rising edge.
   always @(negedge clk) begin
      bit can_in;
      if (mon_en) begin
         check("sb_valid", 32'(out_valid), 32'(sb_q.size() != 0));
         check("sb_ready", 32'(in_ready), 32'(sb_q.size() < 2));
         if (sb_q.size() != 0) check("sb_data", 32'(out_data), 32'(sb_q[0]));
         else                  check("sb_bubble", 32'(out_data), 32'(BUB));
         if (hold_pend) check("hold", 32'(out_data), 32'(hold_data));
      end
      hold_pend = rst_n && !flush && out_valid && !out_ready;
      hold_data = out_data;
      if (!rst_n) begin
         sb_q.delete();
      end else begin
         can_in = (sb_q.size() < 2);
         if (out_ready && sb_q.size() != 0) void'(sb_q.pop_front());
         if (flush)                    sb_q.delete();
         else if (in_valid && can_in)  sb_q.push_back(in_data);
      end
   end

   initial begin
      int ready_pct;
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h55;
      out_ready = 1'b0;

      // Reset with in_valid high: nothing may be captured.
      step();
      mon_en = 1'b1;
      step();
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_data",  32'(out_data),  32'(BUB));
      check("rst_ready", 32'(in_ready),  32'h1);

      // Back-to-back streaming, 1-cycle latency.
      rst_n     = 1'b1;
      out_ready = 1'b1;
      in_data   = 8'h11;
      step();
      check("strm_v1", 32'(out_valid), 32'h1);
      check("strm_d1", 32'(out_data), 32'h11);
      in_data = 8'h22;
      step();
      check("strm_d2", 32'(out_data), 32'h22);
      in_data = 8'h33;
      step();
      check("strm_d3", 32'(out_data), 32'h33);
      in_valid = 1'b0;
      step();
      check("strm_empty", 32'(out_valid), 32'h0);
      check("strm_bubble", 32'(out_data), 32'(BUB));

      // Skid: two entries under back-pressure, then drain in order.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'hA1;
      step();
      in_data = 8'hA2;
      step();
      check("skid_ready0", 32'(in_ready), 32'h0);
      check("skid_hold1", 32'(out_data), 32'hA1);
      in_valid = 1'b0;
      in_data  = 8'h5A;
      step();
      check("skid_hold2", 32'(out_data), 32'hA1);
      out_ready = 1'b1;
      step();
      check("skid_d2", 32'(out_data), 32'hA2);
      check("skid_ready1", 32'(in_ready), 32'h1);
      step();
      check("skid_drained", 32'(out_valid), 32'h0);

      // Flush while full with a competing input transfer.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'hB1;
      step();
      in_data = 8'hB2;
      step();
      in_data = 8'hB3;
      flush   = 1'b1;
      step();
      check("flush_valid", 32'(out_valid), 32'h0);
      check("flush_data",  32'(out_data),  32'(BUB));
      check("flush_ready", 32'(in_ready),  32'h1);
      flush    = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      check("flush_no_b3", 32'(out_valid), 32'h0);

      // Reset mid-stall discards both entries.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'hC1;
      step();
      in_data = 8'hC2;
      step();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      step();
      check("rst_stall_valid", 32'(out_valid), 32'h0);
      check("rst_stall_ready", 32'(in_ready),  32'h1);
      rst_n = 1'b1;

      // Random traffic with occasional flush; scoreboard checks every cycle.
      ready_pct = 50;
      for (int i = 0; i < 10000; i++) begin
         if (i % 500 == 0) ready_pct = (i / 500) % 3 == 0 ? 20 : ((i / 500) % 3 == 1 ? 50 : 90);
         in_valid  = ($urandom_range(0, 99) < 60);
         out_ready = ($urandom_range(0, 99) < ready_pct);
         flush     = ($urandom_range(0, 63) == 0);
         in_data   = 8'($urandom);
         step();
      end
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      step();

`ifdef PIPE_STATS_EN
      // Stall counter saturation; flush must not clear it.
      rst_n = 1'b0;
      step();
      check("cnt_rst", 32'(stall_cycles), 32'h0);
      rst_n     = 1'b1;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'hD1;
      step();
      in_valid = 1'b0;
      check("cnt_start", 32'(stall_cycles), 32'h0);
      repeat (5) step();
      check("cnt_5", 32'(stall_cycles), 32'h5);
      repeat (15) step();
      check("cnt_sat", 32'(stall_cycles), 32'hF);
      flush = 1'b1;
      step();
      flush = 1'b0;
      step();
      check("cnt_flush", 32'(stall_cycles), 32'hF);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
